// File: rtl/key_pulse_conditioner_pkg.sv
// Shared encodings and default timing constants for the key pulse conditioner.
// Defaults assume a 50 MHz clock.
package key_pulse_conditioner_pkg;

  localparam logic [1:0] KP_IDLE         = 2'd0;
  localparam logic [1:0] KP_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] KP_HELD         = 2'd2;
  localparam logic [1:0] KP_RELEASE_WAIT = 2'd3;

  localparam int unsigned KP_NUM_KEYS        = 3;
  localparam int unsigned KP_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned KP_LONG_CYCLES     = 50_000_000;

  // Counter width able to hold max_count without wrapping.
  function automatic int unsigned kp_cnt_w(input int unsigned max_count);
    return 32'($clog2(max_count)) + 32'd1;
  endfunction

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Key inputs and conditioned strobes/levels. The release strobe is named
// release_pulse because "release" is a reserved word.
interface key_pulse_conditioner_if #(
  parameter int unsigned NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] long_press;
  logic                any_press;

  modport master (
    output key_n,
    input  press, release_pulse, held, long_press, any_press
  );

  modport slave (
    input  key_n,
    output press, release_pulse, held, long_press, any_press
  );
endinterface

// File: rtl/key_pulse_conditioner_key_channel.sv
// One key: 2-FF synchroniser, debounce/hold FSM, debounce and long-press counters.
// o_press_c is the next-cycle press value so the top can register any_press in step.
module key_channel
  import key_pulse_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = KP_LONG_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press,
  output logic o_release,
  output logic o_held,
  output logic o_long_press,
  output logic o_press_c
);

  localparam int unsigned DW = kp_cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned LW = kp_cnt_w(LONG_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);

  logic [1:0]    r_sync;
  logic          w_s;
  logic [1:0]    r_state, w_state_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt;
  logic [LW-1:0] r_lcnt, w_lcnt_nxt;
  logic          r_press, w_press_nxt;
  logic          r_release, w_release_nxt;
  logic          r_held, w_held_nxt;
  logic          r_long, w_long_nxt;

  assign w_s = r_sync[1];

  // Synchroniser presets to released so reset never looks like a press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_key_n};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= KP_IDLE;
      r_dcnt    <= '0;
      r_lcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_lcnt    <= w_lcnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_held    <= w_held_nxt;
      r_long    <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_lcnt_nxt    = r_lcnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;

    // Long-press counting continues through release bouncing; saturation makes it one-shot.
    if (r_state == KP_HELD || r_state == KP_RELEASE_WAIT) begin
      if (r_lcnt != LCNT_MAX) w_lcnt_nxt = r_lcnt + LW'(1);
      if (r_lcnt == LCNT_LAST) w_long_nxt = 1'b1;
    end

    case (r_state)
      KP_IDLE: begin
        if (!w_s) begin
          w_state_nxt = KP_PRESS_WAIT;
          w_dcnt_nxt  = '0;
        end
      end
      KP_PRESS_WAIT: begin
        if (w_s) begin
          w_state_nxt = KP_IDLE;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt = KP_HELD;
          w_dcnt_nxt  = '0;
          w_lcnt_nxt  = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      KP_HELD: begin
        if (w_s) begin
          w_state_nxt = KP_RELEASE_WAIT;
          w_dcnt_nxt  = '0;
        end
      end
      KP_RELEASE_WAIT: begin
        if (!w_s) begin
          w_state_nxt = KP_HELD;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt   = KP_IDLE;
          w_dcnt_nxt    = '0;
          w_lcnt_nxt    = '0;
          w_long_nxt    = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      default: begin
        w_state_nxt = KP_IDLE;
        w_dcnt_nxt  = '0;
        w_lcnt_nxt  = '0;
      end
    endcase

    w_held_nxt = (w_state_nxt == KP_HELD) || (w_state_nxt == KP_RELEASE_WAIT);
  end

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_held       = r_held;
  assign o_long_press = r_long;
  assign o_press_c    = w_press_nxt;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounced press/release/held/long-press conditioning for NUM_KEYS raw active-low keys,
// plus an any_press strobe aligned with the per-key press strobes.
module key_pulse_conditioner
  import key_pulse_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = KP_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = KP_LONG_CYCLES
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  key_pulse_conditioner_if.slave  kp
);

  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_held;
  logic [NUM_KEYS-1:0] w_long;
  logic [NUM_KEYS-1:0] w_press_c;
  logic                r_any_press;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .i_clk       (CLOCK_50),
      .i_rst       (reset),
      .i_key_n     (kp.key_n[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_held      (w_held[g]),
      .o_long_press(w_long[g]),
      .o_press_c   (w_press_c[g])
    );
  end

  // Registered from the channels' next-press values so it lands with press[].
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_any_press <= 1'b0;
    else       r_any_press <= |w_press_c;
  end

  assign kp.press         = w_press;
  assign kp.release_pulse = w_release;
  assign kp.held          = w_held;
  assign kp.long_press    = w_long;
  assign kp.any_press     = r_any_press;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Cycle k counts clock edges after the input change; outputs are sampled 1 ns after each edge.
module tb_key_pulse_conditioner;

  localparam int unsigned NK = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  key_pulse_conditioner_if #(.NUM_KEYS(NK)) kp_if ();

  key_pulse_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .kp      (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int k,
                          input logic [NK-1:0] e_press, input logic [NK-1:0] e_rel,
                          input logic [NK-1:0] e_held, input logic [NK-1:0] e_long,
                          input logic e_any);
    chk($sformatf("%s press k%0d", tag, k),   32'(kp_if.press),         32'(e_press));
    chk($sformatf("%s release k%0d", tag, k), 32'(kp_if.release_pulse), 32'(e_rel));
    chk($sformatf("%s held k%0d", tag, k),    32'(kp_if.held),          32'(e_held));
    chk($sformatf("%s long k%0d", tag, k),    32'(kp_if.long_press),    32'(e_long));
    chk($sformatf("%s any k%0d", tag, k),     32'(kp_if.any_press),     32'(e_any));
  endtask

  // Press keys in mask (others released) and check press at edge 7, held from edge 7.
  task automatic press_seq(input string tag, input logic [NK-1:0] mask, input int n,
                           input logic [NK-1:0] pre_held);
    kp_if.key_n = ~(mask | pre_held);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk_outs(tag, k, (k == 7) ? mask : '0, '0,
               (k >= 7) ? (mask | pre_held) : pre_held, '0, k == 7);
    end
  endtask

  // Clean release of every key; release strobe at edge 7, held drops with it.
  task automatic release_seq(input string tag, input logic [NK-1:0] mask, input int n);
    kp_if.key_n = '1;
    for (int k = 1; k <= n; k++) begin
      tick();
      chk_outs(tag, k, '0, (k == 7) ? mask : '0, (k < 7) ? mask : '0, '0, 1'b0);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    kp_if.key_n = '1;
    #2;
    chk_outs("reset", 0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    chk_outs("reset", 1, '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // 1: clean press of key 0 held 30 clocks, long press at edge 27
    kp_if.key_n = 3'b110;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_outs("t1", k, (k == 7) ? 3'b001 : 3'b000, 3'b000,
               (k >= 7) ? 3'b001 : 3'b000, (k == 27) ? 3'b001 : 3'b000, k == 7);
    end
    release_seq("t1r", 3'b001, 10);

    // 2: key 1 low for only 3 clocks is rejected
    kp_if.key_n = 3'b101;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) kp_if.key_n = 3'b111;
      chk_outs("t2", k, '0, '0, '0, '0, 1'b0);
    end

    // 3: key 2 press, then release with a 2-clock bounce
    press_seq("t3p", 3'b100, 10, 3'b000);
    kp_if.key_n = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) kp_if.key_n = 3'b011;
      if (k == 4) kp_if.key_n = 3'b111;
      chk_outs("t3r", k, '0, (k == 11) ? 3'b100 : 3'b000,
               (k < 11) ? 3'b100 : 3'b000, '0, 1'b0);
    end

    // 4: keys 0 and 2 together
    press_seq("t4p", 3'b101, 10, 3'b000);
    release_seq("t4r", 3'b101, 10);

    // 5: asynchronous reset while key 0 is held, key kept low through reset
    press_seq("t5p", 3'b001, 10, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("t5async", 0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    chk_outs("t5rst", 0, '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    press_seq("t5post", 3'b001, 12, 3'b000);
    release_seq("t5r", 3'b001, 10);

    // 6: short hold of key 1, no long press
    press_seq("t6p", 3'b010, 10, 3'b000);
    release_seq("t6r", 3'b010, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
